register_file: RTL and testbench

Eight-entry, 16-bit general-purpose register file that sits directly upstream of the ALU in the single-cycle datapath. Its two read ports drive the ALU `input1`/`input2` operands. Its write port accepts the ALU result, or any other write-back source, at the end of the cycle. It also keeps registered zero/negative status flags for the last committed write, which later branch logic consumes.

---
 rtl/register_file.sv | 72 +++++++
 tb/tb_register_file.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Eight-entry register file with R0 hardwired to zero and zero/negative flags for the last committed write.
// Reads are combinational (0 cycles) with no write bypass; writes and flags land at the next edge; no backpressure.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readAddr1,
  input  logic [ADDR_WIDTH-1:0] readAddr2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic                  zeroFlag,
  output logic                  negFlag
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  zero_flag_q, zero_flag_d;
  logic                  neg_flag_q,  neg_flag_d;
  logic                  commit;

  // writeEnable gates the address compare, so an X address while idle cannot reach the array.
  assign commit = writeEnable && (writeAddr != '0);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (writeAddr == ADDR_WIDTH'(i))) begin
        regs_d[i] = writeData;
      end
    end
    regs_d[0] = '0;
  end

  always_comb begin
    zero_flag_d = zero_flag_q;
    neg_flag_d  = neg_flag_q;
    if (commit) begin
      zero_flag_d = (writeData == '0);
      neg_flag_d  = writeData[DATA_WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      zero_flag_q <= 1'b0;
      neg_flag_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      zero_flag_q <= zero_flag_d;
      neg_flag_q  <= neg_flag_d;
    end
  end

  // R0 is forced at the read mux so it reads zero even before the first reset.
  assign readData1 = (readAddr1 == '0) ? '0 : regs_q[readAddr1];
  assign readData2 = (readAddr2 == '0) ? '0 : regs_q[readAddr2];
  assign zeroFlag  = zero_flag_q;
  assign negFlag   = neg_flag_q;

endmodule

// File: tb/tb_register_file.sv
// Directed table-driven bench for register_file plus hand sequences for reset and X-address corners.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        writeEnable;
  logic [2:0]  writeAddr;
  logic [15:0] writeData;
  logic [2:0]  readAddr1;
  logic [2:0]  readAddr2;
  logic [15:0] readData1;
  logic [15:0] readData2;
  logic        zeroFlag;
  logic        negFlag;

  int checks   = 0;
  int failures = 0;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .readAddr1   (readAddr1),
    .readAddr2   (readAddr2),
    .readData1   (readData1),
    .readData2   (readData2),
    .zeroFlag    (zeroFlag),
    .negFlag     (negFlag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [15:0] exp1;   // read ports before the edge
    logic [15:0] exp2;
    logic        expz;   // flags after the edge
    logic        expn;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  logic [15:0] exp_regs [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_regs(input string tag);
    for (int a = 0; a < 8; a++) begin
      readAddr1 = 3'(a);
      readAddr2 = 3'(7 - a);
      #1;
      check($sformatf("%s rd1 R%0d", tag, a), readData1, exp_regs[a]);
      check($sformatf("%s rd2 R%0d", tag, 7 - a), readData2, exp_regs[7 - a]);
    end
  endtask

  initial begin
    reset = 1'b1; writeEnable = 1'b0; writeAddr = '0; writeData = '0;
    readAddr1 = '0; readAddr2 = '0;
    tick();
    reset = 1'b0;
    check("flag zero after reset", 16'(zeroFlag), 16'h0);
    check("flag neg after reset", 16'(negFlag), 16'h0);

    // Preload R1..R7 with nonzero data, then reset again.
    for (int i = 1; i < 8; i++) begin
      writeEnable = 1'b1; writeAddr = 3'(i); writeData = 16'h1111 * 16'(i) + 16'h8000;
      tick();
    end
    writeEnable = 1'b0;
    exp_regs[0] = 16'h0;
    for (int i = 1; i < 8; i++) exp_regs[i] = 16'h1111 * 16'(i) + 16'h8000;
    check_all_regs("preload");
    check("flag neg after preload", 16'(negFlag), 16'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0;
    check_all_regs("reset");
    check("flag zero after 2nd reset", 16'(zeroFlag), 16'h0);
    check("flag neg after 2nd reset", 16'(negFlag), 16'h0);

    vecs[0]  = '{1'b1, 3'd3, 16'h1234, 3'd3, 3'd5, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd5, 16'hABCD, 3'd3, 3'd5, 16'h1234, 16'h0000, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd5, 16'h0000, 16'hABCD, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 3'd2, 16'h0005, 3'd3, 3'd5, 16'h1234, 16'hABCD, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 3'd2, 16'h0007, 3'd2, 3'd2, 16'h0005, 16'h0005, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'd4, 16'h0000, 3'd2, 3'd2, 16'h0007, 16'h0007, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 3'd4, 16'h8000, 3'd4, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 3'd7, 16'hFFFF, 3'd7, 3'd1, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 3'd7, 16'h8000, 3'd7, 3'd4, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 3'd1, 16'h7FFF, 3'd7, 3'd1, 16'h8000, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd7, 16'h7FFF, 16'h8000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'd0, 16'h0000, 3'd0, 3'd1, 16'h0000, 16'h7FFF, 1'b0, 1'b0};

    for (int k = 0; k < NV; k++) begin
      writeEnable = vecs[k].we; writeAddr = vecs[k].wa; writeData = vecs[k].wd;
      readAddr1 = vecs[k].ra1; readAddr2 = vecs[k].ra2;
      #1;
      check($sformatf("vec%0d rd1", k), readData1, vecs[k].exp1);
      check($sformatf("vec%0d rd2", k), readData2, vecs[k].exp2);
      tick();
      check($sformatf("vec%0d zero", k), 16'(zeroFlag), 16'(vecs[k].expz));
      check($sformatf("vec%0d neg", k), 16'(negFlag), 16'(vecs[k].expn));
    end
    writeEnable = 1'b0;

    // Read-after-write visibility for the register written in the same-cycle case.
    readAddr1 = 3'd2; readAddr2 = 3'd2;
    #1;
    check("raw rd1 R2 new", readData1, 16'h0007);
    check("raw rd2 R2 new", readData2, 16'h0007);

    // X on writeAddr while writeEnable is low must leave everything intact.
    exp_regs[0] = 16'h0000; exp_regs[1] = 16'h7FFF; exp_regs[2] = 16'h0007; exp_regs[3] = 16'h1234;
    exp_regs[4] = 16'h0000; exp_regs[5] = 16'hABCD; exp_regs[6] = 16'h0000; exp_regs[7] = 16'h8000;
    writeEnable = 1'b0; writeAddr = 3'bxxx; writeData = 16'hFFFF;
    tick();
    writeAddr = 3'd0;
    check_all_regs("xaddr");
    check("xaddr zero", 16'(zeroFlag), 16'h0);
    check("xaddr neg", 16'(negFlag), 16'h0);

    // Reset and a write on the same edge: reset wins; reads before the edge still show old contents.
    writeEnable = 1'b1; writeAddr = 3'd3; writeData = 16'h8000;
    tick();
    check("pre-rst neg", 16'(negFlag), 16'h1);
    reset = 1'b1; writeEnable = 1'b1; writeAddr = 3'd6; writeData = 16'h00AA;
    readAddr1 = 3'd3; readAddr2 = 3'd5;
    #1;
    check("rst cycle rd1 R3 old", readData1, 16'h8000);
    check("rst cycle rd2 R5 old", readData2, 16'hABCD);
    tick();
    reset = 1'b0; writeEnable = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0;
    check_all_regs("rst+wr");
    check("rst+wr zero", 16'(zeroFlag), 16'h0);
    check("rst+wr neg", 16'(negFlag), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
